imul_resp_accum: RTL and testbench

//   Downstream consumer of the integer multiplier's 32-bit response stream.

---
 rtl/imul_pkg.sv | 22 ++
 rtl/imul_resp_accum_dpath.sv | 56 +++++
 rtl/imul_resp_accum.sv | 106 ++++++++++
 tb/tb_imul_resp_accum.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/imul_pkg.sv
// Shared types for the multiplier response accumulator: FSM states,
// accumulator mux selects and the control word the FSM drives into the datapath.
package imul_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_ACC  = 2'd1,
        STATE_DONE = 2'd2
    } state_t;

    localparam logic [1:0] ACC_SEL_CLR  = 2'd0;
    localparam logic [1:0] ACC_SEL_ADD  = 2'd1;
    localparam logic [1:0] ACC_SEL_HOLD = 2'd2;

    typedef struct packed {
        logic [1:0] acc_sel;
        logic       len_en;
        logic       count_clr;
        logic       count_inc;
    } ctrl_t;

endpackage

// File: rtl/imul_resp_accum_dpath.sv
// Datapath of the response accumulator: sum register, group-length register
// and product counter, plus the status bits the control FSM branches on.
module imul_resp_accum_dpath
    import imul_pkg::*;
#(
    parameter int p_nbits     = 32,
    parameter int p_len_nbits = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  ctrl_t                  ctrl,
    input  logic [p_len_nbits-1:0] cfg_msg,
    input  logic [p_nbits-1:0]     in_msg,
    output logic [p_nbits-1:0]     acc,
    output logic                   count_is_last,
    output logic                   len_is_zero
);

    localparam logic [p_len_nbits-1:0] LEN_ONE = p_len_nbits'(1);

    logic [p_len_nbits-1:0] len_r;
    logic [p_len_nbits-1:0] count_r;
    logic [p_nbits-1:0]     acc_r;
    logic [p_nbits-1:0]     acc_next;

    always_comb begin
        acc_next = acc_r;
        case (ctrl.acc_sel)
            ACC_SEL_CLR:  acc_next = '0;
            ACC_SEL_ADD:  acc_next = acc_r + in_msg;
            default:      acc_next = acc_r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r   <= '0;
            len_r   <= '0;
            count_r <= '0;
        end else begin
            acc_r <= acc_next;
            if (ctrl.len_en)
                len_r <= cfg_msg;
            if (ctrl.count_clr)
                count_r <= '0;
            else if (ctrl.count_inc)
                count_r <= count_r + LEN_ONE;
        end
    end

    // len is never zero while accumulating, so len-1 cannot underflow here.
    assign count_is_last = (count_r == (len_r - LEN_ONE));
    assign len_is_zero   = (cfg_msg == '0);
    assign acc           = acc_r;

endmodule

// File: rtl/imul_resp_accum.sv
// Reduction stage of a dot-product pipeline: sums cfg_msg products from the
// multiplier response stream and emits one wrapped sum per group.
module imul_resp_accum
    import imul_pkg::*;
#(
    parameter int p_nbits     = 32,
    parameter int p_len_nbits = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_val,
    output logic                   cfg_rdy,
    input  logic [p_len_nbits-1:0] cfg_msg,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [p_nbits-1:0]     in_msg,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [p_nbits-1:0]     out_msg
);

    // Handshake rule on every port: a transfer happens on the rising edge where
    // val && rdy; every rdy/val driven here is a registered function of state only.

    state_t state;
    ctrl_t  ctrl;
    logic   count_is_last;
    logic   len_is_zero;

    imul_resp_accum_dpath #(
        .p_nbits     (p_nbits),
        .p_len_nbits (p_len_nbits)
    ) dpath (
        .clk           (clk),
        .reset         (reset),
        .ctrl          (ctrl),
        .cfg_msg       (cfg_msg),
        .in_msg        (in_msg),
        .acc           (out_msg),
        .count_is_last (count_is_last),
        .len_is_zero   (len_is_zero)
    );

    task automatic cs(output ctrl_t c, input logic [1:0] acc_sel,
                      input logic len_en, input logic count_clr, input logic count_inc);
        c.acc_sel   = acc_sel;
        c.len_en    = len_en;
        c.count_clr = count_clr;
        c.count_inc = count_inc;
    endtask

    always_comb begin
        cs(ctrl, ACC_SEL_HOLD, 1'b0, 1'b0, 1'b0);
        case (state)
            STATE_IDLE: if (cfg_val) cs(ctrl, ACC_SEL_CLR, 1'b1, 1'b1, 1'b0);
            STATE_ACC:  if (in_val)  cs(ctrl, ACC_SEL_ADD, 1'b0, 1'b0, 1'b1);
            STATE_DONE: if (out_rdy) cs(ctrl, ACC_SEL_CLR, 1'b0, 1'b1, 1'b0);
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= STATE_IDLE;
            cfg_rdy <= 1'b1;
            in_rdy  <= 1'b0;
            out_val <= 1'b0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (cfg_val) begin
                        cfg_rdy <= 1'b0;
                        if (len_is_zero) begin
                            state   <= STATE_DONE;
                            out_val <= 1'b1;
                        end else begin
                            state  <= STATE_ACC;
                            in_rdy <= 1'b1;
                        end
                    end
                end
                STATE_ACC: begin
                    if (in_val && count_is_last) begin
                        state   <= STATE_DONE;
                        in_rdy  <= 1'b0;
                        out_val <= 1'b1;
                    end
                end
                STATE_DONE: begin
                    if (out_rdy) begin
                        state   <= STATE_IDLE;
                        out_val <= 1'b0;
                        cfg_rdy <= 1'b1;
                    end
                end
                default: begin
                    state   <= STATE_IDLE;
                    cfg_rdy <= 1'b1;
                    in_rdy  <= 1'b0;
                    out_val <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imul_resp_accum.sv
// Directed bench for imul_resp_accum: inputs change and outputs are checked
// on the falling edge, transfers happen on the rising edge.
module tb_imul_resp_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_val;
    logic        cfg_rdy;
    logic [7:0]  cfg_msg;
    logic        in_val;
    logic        in_rdy;
    logic [31:0] in_msg;
    logic        out_val;
    logic        out_rdy;
    logic [31:0] out_msg;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imul_resp_accum #(
        .p_nbits     (32),
        .p_len_nbits (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cfg_val (cfg_val),
        .cfg_rdy (cfg_rdy),
        .cfg_msg (cfg_msg),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_msg  (in_msg),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_msg (out_msg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cfg_send(input logic [7:0] len);
        int budget = 0;
        cfg_msg = len;
        cfg_val = 1'b1;
        while (!cfg_rdy && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!cfg_rdy) chk("cfg_rdy_wait", 32'(cfg_rdy), 32'd1);
        @(negedge clk);
        cfg_val = 1'b0;
    endtask

    task automatic send(input logic [31:0] p, input int gap);
        int budget = 0;
        repeat (gap) @(negedge clk);
        in_msg = p;
        in_val = 1'b1;
        while (!in_rdy && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!in_rdy) chk("in_rdy_wait", 32'(in_rdy), 32'd1);
        @(negedge clk);
        in_val = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [31:0] sum;
        reset = 1'b1; cfg_val = 1'b0; cfg_msg = '0;
        in_val = 1'b0; in_msg = '0; out_rdy = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_cfg_rdy", 32'(cfg_rdy), 32'd1);
        chk("rst_in_rdy",  32'(in_rdy),  32'd0);
        chk("rst_out_val", 32'(out_val), 32'd0);
        chk("rst_out_msg", out_msg,      32'd0);

        // 1: len=3, 6+7+8 back-to-back
        out_rdy = 1'b1;
        cfg_send(8'd3);
        chk("t1_in_rdy", 32'(in_rdy), 32'd1);
        send(32'd6, 0); send(32'd7, 0); send(32'd8, 0);
        chk("t1_out_val", 32'(out_val), 32'd1);
        chk("t1_out_msg", out_msg,      32'd21);
        chk("t1_in_rdy_done", 32'(in_rdy), 32'd0);
        @(negedge clk);
        chk("t1_cfg_rdy", 32'(cfg_rdy), 32'd1);
        chk("t1_out_val_clr", 32'(out_val), 32'd0);
        chk("t1_out_msg_clr", out_msg, 32'd0);

        // 2: len=0 goes straight to DONE with a zero sum
        out_rdy = 1'b0;
        cfg_send(8'd0);
        chk("t2_out_val", 32'(out_val), 32'd1);
        chk("t2_out_msg", out_msg,      32'd0);
        chk("t2_in_rdy",  32'(in_rdy),  32'd0);
        out_rdy = 1'b1;
        @(negedge clk);
        chk("t2_cfg_rdy", 32'(cfg_rdy), 32'd1);

        // 3: wrap-around; a stray cfg_val mid-group must be ignored
        cfg_send(8'd2);
        send(32'hFFFF_FFFF, 0);
        cfg_msg = 8'd0; cfg_val = 1'b1;
        @(negedge clk);
        cfg_val = 1'b0;
        chk("t3_cfg_ignored_in_rdy", 32'(in_rdy), 32'd1);
        chk("t3_cfg_ignored_out_val", 32'(out_val), 32'd0);
        send(32'h0000_0002, 0);
        chk("t3_out_val", 32'(out_val), 32'd1);
        chk("t3_out_msg", out_msg,      32'h0000_0001);
        @(negedge clk);

        // 4: random gaps, then 5 cycles of backpressure with junk on in_val
        out_rdy = 1'b0;
        cfg_send(8'd4);
        for (int i = 1; i <= 4; i++) send(32'(i), $urandom_range(0, 3));
        chk("t4_out_val", 32'(out_val), 32'd1);
        chk("t4_out_msg", out_msg,      32'd10);
        in_val = 1'b1; in_msg = 32'd99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_val", 32'(out_val), 32'd1);
            chk("t4_hold_msg", out_msg,      32'd10);
            chk("t4_hold_in_rdy", 32'(in_rdy), 32'd0);
        end
        in_val = 1'b0;
        out_rdy = 1'b1;
        @(negedge clk);
        chk("t4_released_val", 32'(out_val), 32'd0);
        chk("t4_released_cfg_rdy", 32'(cfg_rdy), 32'd1);

        // 5: reset mid-group discards the partial sum
        cfg_send(8'd5);
        send(32'd3, 0); send(32'd4, 0);
        chk("t5_no_out_val", 32'(out_val), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_rst_cfg_rdy", 32'(cfg_rdy), 32'd1);
        chk("t5_rst_in_rdy",  32'(in_rdy),  32'd0);
        chk("t5_rst_out_val", 32'(out_val), 32'd0);
        chk("t5_rst_out_msg", out_msg,      32'd0);
        out_rdy = 1'b0;
        cfg_send(8'd1);
        send(32'd9, 0);
        chk("t5_out_val", 32'(out_val), 32'd1);
        chk("t5_out_msg", out_msg,      32'd9);
        out_rdy = 1'b1;
        @(negedge clk);

        // 6: products of (2,3),(4,5),(6,7) from a multiplier-like source
        out_rdy = 1'b0;
        cfg_send(8'd3);
        send(32'd2 * 32'd3, $urandom_range(0, 4));
        send(32'd4 * 32'd5, $urandom_range(0, 4));
        send(32'd6 * 32'd7, $urandom_range(0, 4));
        k = $urandom_range(1, 6);
        for (int i = 0; i < k; i++) begin
            chk("t6_out_val", 32'(out_val), 32'd1);
            chk("t6_out_msg", out_msg,      32'd68);
            @(negedge clk);
        end
        out_rdy = 1'b1;
        @(negedge clk);
        chk("t6_cfg_rdy", 32'(cfg_rdy), 32'd1);

        // 7: maximum group length 255, products 1..255
        out_rdy = 1'b0;
        cfg_send(8'd255);
        for (int i = 1; i <= 254; i++) send(32'(i), 0);
        chk("t7_not_done_val", 32'(out_val), 32'd0);
        chk("t7_not_done_rdy", 32'(in_rdy),  32'd1);
        send(32'd255, 0);
        sum = 32'd32640;
        chk("t7_out_val", 32'(out_val), 32'd1);
        chk("t7_out_msg", out_msg,      sum);
        out_rdy = 1'b1;
        @(negedge clk);
        chk("t7_cfg_rdy", 32'(cfg_rdy), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
